// File: rtl/ha_array_accum_ctrl.sv
// Sequencing controller for an external half-adder-array multiplier: captures the
// array's row vectors, accumulates them row by row and returns a 16-bit product.
module ha_array_accum_ctrl #(
    parameter int SAT_EN = 1,
    parameter int ACC_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  mul_x,
    output logic [7:0]  mul_y,
    input  logic [6:0]  ha_b0,
    input  logic [6:0]  ha_b1,
    input  logic [6:0]  ha_b2,
    input  logic [6:0]  ha_b3,
    input  logic [8:0]  ha_t0,
    input  logic [8:0]  ha_t1,
    input  logic [8:0]  ha_t2,
    input  logic [8:0]  ha_t3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_sat,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACC     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       op_x_q;
    logic [7:0]       op_y_q;
    logic [6:0]       row_b_q [4];
    logic [8:0]       row_t_q [4];
    logic [1:0]       rc_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [15:0]      out_p_q;
    logic             out_sat_q;
    logic [16:0]      clip_d;

    // Row k carries weight 4^k; its b vector sits two bit positions above t.
    function automatic logic [ACC_W-1:0] row_val(input logic [8:0] t, input logic [6:0] b,
                                                 input logic [1:0] k);
        logic [ACC_W-1:0] s;
        s = ACC_W'(t) + (ACC_W'(b) << 2);
        return s << {k, 1'b0};
    endfunction

    // Returns {clipped, value16}.
    function automatic logic [16:0] clip16(input logic [ACC_W-1:0] a);
        if ((SAT_EN != 0) && (|a[ACC_W-1:16])) begin
            return {1'b1, 16'hFFFF};
        end
        return {1'b0, a[15:0]};
    endfunction

    always_comb begin
        acc_d  = acc_q + row_val(row_t_q[rc_q], row_b_q[rc_q], rc_q);
        clip_d = clip16(acc_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_x_q    <= '0;
            op_y_q    <= '0;
            rc_q      <= '0;
            acc_q     <= '0;
            out_p_q   <= '0;
            out_sat_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                row_b_q[k] <= '0;
                row_t_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_x_q  <= in_x;
                        op_y_q  <= in_y;
                        acc_q   <= '0;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    row_b_q[0] <= ha_b0;
                    row_b_q[1] <= ha_b1;
                    row_b_q[2] <= ha_b2;
                    row_b_q[3] <= ha_b3;
                    row_t_q[0] <= ha_t0;
                    row_t_q[1] <= ha_t1;
                    row_t_q[2] <= ha_t2;
                    row_t_q[3] <= ha_t3;
                    rc_q       <= '0;
                    state_q    <= ACC;
                end
                ACC: begin
                    acc_q <= acc_d;
                    rc_q  <= rc_q + 2'd1;
                    // Result registers load from the final sum on the way into DONE.
                    if (rc_q == 2'd3) begin
                        out_p_q   <= clip_d[15:0];
                        out_sat_q <= clip_d[16];
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign mul_x     = op_x_q;
    assign mul_y     = op_y_q;
    assign out_p     = out_p_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_ha_array_accum_ctrl.sv
// Scoreboard bench for ha_array_accum_ctrl: a saturating and a truncating instance
// share one stimulus stream and an approximate HA-array multiplier model.
module tb_ha_array_accum_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid;
    logic [7:0]      in_x;
    logic [7:0]      in_y;
    logic            out_ready;
    logic [3:0][8:0] ha_t, nz_t, frc_t;
    logic [3:0][6:0] ha_b, nz_b, frc_b;
    logic [3:0][15:0] mdl;
    bit              cap_win, use_model, rdy_fixed, rdy_rand, rnd_rdy;

    logic        s_in_ready, s_out_valid, s_out_sat, s_busy;
    logic [7:0]  s_mul_x, s_mul_y;
    logic [15:0] s_out_p;
    logic        t_in_ready, t_out_valid, t_out_sat, t_busy;
    logic [7:0]  t_mul_x, t_mul_y;
    logic [15:0] t_out_p;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int last_acc = -1;

    typedef struct {
        logic [15:0] p1;
        logic        s1;
        logic [15:0] p0;
        int          acyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   first_seen = 1'b0;

    ha_array_accum_ctrl #(.SAT_EN(1), .ACC_W(18)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_x(in_x), .in_y(in_y), .mul_x(s_mul_x), .mul_y(s_mul_y),
        .ha_b0(ha_b[0]), .ha_b1(ha_b[1]), .ha_b2(ha_b[2]), .ha_b3(ha_b[3]),
        .ha_t0(ha_t[0]), .ha_t1(ha_t[1]), .ha_t2(ha_t[2]), .ha_t3(ha_t[3]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p),
        .out_sat(s_out_sat), .busy(s_busy)
    );

    ha_array_accum_ctrl #(.SAT_EN(0), .ACC_W(17)) u_trn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_x(in_x), .in_y(in_y), .mul_x(t_mul_x), .mul_y(t_mul_y),
        .ha_b0(ha_b[0]), .ha_b1(ha_b[1]), .ha_b2(ha_b[2]), .ha_b3(ha_b[3]),
        .ha_t0(ha_t[0]), .ha_t1(ha_t[1]), .ha_t2(ha_t[2]), .ha_t3(ha_t[3]),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_p(t_out_p),
        .out_sat(t_out_sat), .busy(t_busy)
    );

    // Approximate HA array: row k pairs x[2k] (weight 0) with x[2k+1] (weight 1);
    // t keeps sum bits where only the x[2k] term is present, b keeps the carries.
    function automatic logic [15:0] ha_model(input logic [7:0] x, input logic [7:0] y, input int k);
        logic [8:0] a, c, ac;
        a  = x[2*k]   ? {1'b0, y} : 9'd0;
        c  = x[2*k+1] ? {y, 1'b0} : 9'd0;
        ac = a & c;
        return {a & ~c, ac[7:1]};
    endfunction

    function automatic int ref_acc(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(t[k]) + 4 * int'(b[k])) * (1 << (2 * k));
        end
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd_rdy <= 1'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
            nz_t[k] <= 9'($urandom);
            nz_b[k] <= 7'($urandom);
        end
    end

    assign out_ready = rdy_rand ? rnd_rdy : rdy_fixed;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mdl[k]  = ha_model(s_mul_x, s_mul_y, k);
            ha_t[k] = nz_t[k];
            ha_b[k] = nz_b[k];
            if (cap_win) begin
                if (use_model) begin
                    ha_t[k] = mdl[k][15:7];
                    ha_b[k] = mdl[k][6:0];
                end else begin
                    ha_t[k] = frc_t[k];
                    ha_b[k] = frc_b[k];
                end
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            first_seen = 1'b0;
        end else if (s_out_valid || t_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", int'(s_out_valid | t_out_valid), 0);
            end else begin
                mon_e = exp_q[0];
                if (!first_seen) begin
                    chk("latency", cyc - mon_e.acyc, 6);
                    first_seen = 1'b1;
                end
                chk("sat_out_p", int'(s_out_p), int'(mon_e.p1));
                chk("sat_out_sat", int'(s_out_sat), int'(mon_e.s1));
                chk("trn_out_p", int'(t_out_p), int'(mon_e.p0));
                chk("trn_out_sat", int'(t_out_sat), 0);
                chk("trn_out_valid", int'(t_out_valid), 1);
                chk("in_ready_done", int'(s_in_ready), 0);
                chk("busy_done", int'(s_busy), 1);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    first_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input bit model,
                         input logic [3:0][8:0] ft, input logic [3:0][6:0] fb,
                         input int ovr, input bit keep_valid, input bit chk_gap);
        exp_t e;
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        int a;
        int w;
        for (int k = 0; k < 4; k++) begin
            if (model) begin
                t[k] = ha_model(x, y, k) >> 7;
                b[k] = 7'(ha_model(x, y, k));
            end else begin
                t[k] = ft[k];
                b[k] = fb[k];
            end
        end
        a = (ovr >= 0) ? ovr : ref_acc(t, b);
        e.p1 = (a > 65535) ? 16'hFFFF : 16'(a);
        e.s1 = (a > 65535);
        e.p0 = 16'(a);
        @(negedge clk);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        use_model = model;
        frc_t     = ft;
        frc_b     = fb;
        w = 0;
        while (!s_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            chk("accept_timeout", int'(s_in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e.acyc = cyc;
        if (chk_gap && last_acc >= 0) chk("b2b_period", cyc - last_acc, 7);
        last_acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cap_win  = 1'b1;
        in_valid = 1'b1;
        in_x     = 8'($urandom);
        in_y     = 8'($urandom);
        @(posedge clk);
        #1;
        cap_win  = 1'b0;
        in_valid = keep_valid;
    endtask

    task automatic check_rst();
        chk("rst_in_ready", int'(s_in_ready), 1);
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_out_valid", int'(s_out_valid), 0);
        chk("rst_out_p", int'(s_out_p), 0);
        chk("rst_out_sat", int'(s_out_sat), 0);
        chk("rst_mul_x", int'(s_mul_x), 0);
        chk("rst_mul_y", int'(s_mul_y), 0);
        chk("rst_trn_in_ready", int'(t_in_ready), 1);
        chk("rst_trn_busy", int'(t_busy), 0);
        chk("rst_trn_out_valid", int'(t_out_valid), 0);
        chk("rst_trn_out_p", int'(t_out_p), 0);
        chk("rst_trn_mul_x", int'(t_mul_x), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][8:0] ft;
        logic [3:0][6:0] fb;
        int w;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        cap_win = 1'b0; use_model = 1'b1; rdy_fixed = 1'b1; rdy_rand = 1'b0;
        frc_t = '0; frc_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_rst();

        // Directed small products through the model loop.
        issue(8'h01, 8'h01, 1'b1, '0, '0, 1, 1'b0, 1'b0);
        issue(8'h04, 8'h01, 1'b1, '0, '0, 4, 1'b0, 1'b0);
        issue(8'h03, 8'h03, 1'b1, '0, '0, 5, 1'b0, 1'b0);

        // All-ones rows: overflows 16 bits.
        for (int k = 0; k < 4; k++) begin
            ft[k] = 9'h1FF;
            fb[k] = 7'h7F;
        end
        issue(8'h77, 8'h99, 1'b0, ft, fb, -1, 1'b0, 1'b0);

        // Consumer stall in DONE with new offers being ignored.
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        rdy_fixed = 1'b0;
        issue(8'h5A, 8'hC3, 1'b1, '0, '0, -1, 1'b0, 1'b0);
        w = 0;
        while (!s_out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("hold_reach_done", int'(s_out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_x = 8'($urandom);
            in_y = 8'($urandom);
            @(negedge clk);
            chk("hold_mul_x", int'(s_mul_x), 'h5A);
            chk("hold_mul_y", int'(t_mul_y), 'hC3);
            chk("hold_out_valid", int'(s_out_valid), 1);
        end
        @(posedge clk);
        #1;
        rdy_fixed = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", int'(s_in_ready), 1);
        chk("release_out_valid", int'(s_out_valid), 0);

        // Abort during ACC (rc==2), then a clean operation.
        issue(8'hFF, 8'hFF, 1'b1, '0, '0, -1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_rst();
        issue(8'h04, 8'h01, 1'b1, '0, '0, 4, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        last_acc = -1;
        for (int i = 0; i < 6; i++) begin
            issue(8'($urandom), 8'($urandom), 1'b1, '0, '0, -1, (i < 5), 1'b1);
        end

        // Randomized operands, forced rows and consumer backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < 4; k++) begin
                ft[k] = 9'($urandom);
                fb[k] = 7'($urandom);
            end
            issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ft, fb, -1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
